// File: rtl/robo_pkg.sv
// Shared state encoding and sensor dispatch rule for the wall-following robot controller.
// Latency: purely combinational helpers, no state.
// Backpressure: none; sensors are level signals sampled every cycle.
package robo_pkg;

    localparam int ESTADO_W = 3;

    typedef enum logic [ESTADO_W-1:0] {
        INICIAL           = 3'd0,
        PROCURANDO_MURO   = 3'd1,
        ROTACIONANDO      = 3'd2,
        ACOMPANHANDO_MURO = 3'd3,
        REMOCAO           = 3'd4,
        STANDBY           = 3'd5
    } estado_t;

    // Fixed sensor priority: under > barrier > head > left, otherwise keep searching.
    function automatic estado_t despacho(
        input logic head,
        input logic left,
        input logic under,
        input logic barrier
    );
        estado_t prox;
        if (under) begin
            prox = STANDBY;
        end else if (barrier) begin
            prox = REMOCAO;
        end else if (head) begin
            prox = ROTACIONANDO;
        end else if (left) begin
            prox = ACOMPANHANDO_MURO;
        end else begin
            prox = PROCURANDO_MURO;
        end
        return prox;
    endfunction

endpackage

// File: rtl/robo_temporizador.sv
// Loadable down-counter timing rotation and removal actions; fim is high in the last action cycle.
// Latency: load takes effect on the next edge; fim is decoded from the count register.
// Backpressure: none; a load always wins over counting.
module robo_temporizador #(
    parameter int LARGURA = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               carregar,
    input  logic [LARGURA-1:0] valor,
    output logic               fim
);

    logic [LARGURA-1:0] contagem;

    // Count holds the cycles left in the current action, including the present one.
    always_ff @(posedge clock) begin
        if (reset) begin
            contagem <= '0;
        end else if (carregar) begin
            contagem <= valor;
        end else if (contagem != '0) begin
            contagem <= contagem - 1'b1;
        end
    end

    assign fim = (contagem == LARGURA'(1));

endmodule

// File: rtl/robo_seguidor_param.sv
// Wall-following robot controller with timed rotation/removal, bounded retries; odometer under ROBO_ODOMETRIA_EN.
// Latency: one cycle, all outputs registered; a sensor sampled at edge n shows after edge n.
// Backpressure: none; actions run for fixed cycle counts, only under or reset cut them short.
module robo_seguidor_param
    import robo_pkg::*;
#(
    parameter int GIRO_CICLOS    = 4,
    parameter int REMOCAO_CICLOS = 3,
    parameter int MAX_TENTATIVAS = 2,
    parameter int PASSOS_W       = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                head,
    input  logic                left,
    input  logic                under,
    input  logic                barrier,
    output logic                avancar,
    output logic                girar,
    output logic                remover,
    output logic [ESTADO_W-1:0] estado,
    output logic                erro,
    output logic [PASSOS_W-1:0] passos
);

    localparam int TMR_MAX = (GIRO_CICLOS > REMOCAO_CICLOS) ? GIRO_CICLOS : REMOCAO_CICLOS;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int TENT_W  = $clog2(MAX_TENTATIVAS + 1);

    estado_t             estado_q;
    estado_t             estado_prox;
    logic [TENT_W-1:0]   tentativas;
    logic [TENT_W-1:0]   tentativas_prox;
    logic [TENT_W-1:0]   tentativas_mais;
    logic                erro_set;
    logic                fim;
    logic                carregar;
    logic [TMR_W-1:0]    valor_carga;

    // One timer serves both actions since they never overlap.
    robo_temporizador #(
        .LARGURA (TMR_W)
    ) u_temporizador (
        .clock    (clock),
        .reset    (reset),
        .carregar (carregar),
        .valor    (valor_carga),
        .fim      (fim)
    );

    // Next state, retry bookkeeping and timer load for back-to-back actions.
    always_comb begin
        estado_prox     = estado_q;
        erro_set        = 1'b0;
        tentativas_prox = tentativas;
        tentativas_mais = tentativas + 1'b1;

        case (estado_q)
            INICIAL, PROCURANDO_MURO, ACOMPANHANDO_MURO: begin
                estado_prox = despacho(head, left, under, barrier);
            end
            ROTACIONANDO: begin
                if (under) begin
                    estado_prox = STANDBY;
                end else if (fim) begin
                    estado_prox = despacho(head, left, under, barrier);
                end
            end
            REMOCAO: begin
                if (under) begin
                    estado_prox = STANDBY;
                end else if (fim) begin
                    if (!barrier) begin
                        estado_prox = despacho(head, left, under, barrier);
                    end else if (tentativas_mais == TENT_W'(MAX_TENTATIVAS)) begin
                        estado_prox = STANDBY;
                        erro_set    = 1'b1;
                    end else begin
                        estado_prox     = REMOCAO;
                        tentativas_prox = tentativas_mais;
                    end
                end
            end
            STANDBY: begin
                estado_prox = STANDBY;
            end
            default: begin
                estado_prox = STANDBY;
            end
        endcase

        // Any way out of removal forgets previous failed attempts.
        if (estado_prox != REMOCAO) begin
            tentativas_prox = '0;
        end

        // Reload on a fresh entry or when an action chains into another one at its last cycle.
        carregar    = ((estado_prox == ROTACIONANDO) || (estado_prox == REMOCAO)) &&
                      ((estado_prox != estado_q) || fim);
        valor_carga = (estado_prox == ROTACIONANDO) ? TMR_W'(GIRO_CICLOS) : TMR_W'(REMOCAO_CICLOS);
    end

    // State and Moore outputs are registered together so outputs track the state exactly.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= INICIAL;
            tentativas <= '0;
            erro       <= 1'b0;
            avancar    <= 1'b0;
            girar      <= 1'b0;
            remover    <= 1'b0;
        end else begin
            estado_q   <= estado_prox;
            tentativas <= tentativas_prox;
            erro       <= erro | erro_set;
            avancar    <= (estado_prox == PROCURANDO_MURO) || (estado_prox == ACOMPANHANDO_MURO);
            girar      <= (estado_prox == ROTACIONANDO);
            remover    <= (estado_prox == REMOCAO);
        end
    end

    assign estado = estado_q;

`ifdef ROBO_ODOMETRIA_EN
    logic [PASSOS_W-1:0] passos_q;

    // Count forward-motion cycles, sticking at the top value instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            passos_q <= '0;
        end else if (avancar && (passos_q != '1)) begin
            passos_q <= passos_q + 1'b1;
        end
    end

    assign passos = passos_q;
`else
    assign passos = '0;
`endif

endmodule

// File: tb/tb_robo_seguidor_param.sv
// Self-checking bench for robo_seguidor_param: directed table, odometer runs and randomized model compare.
// Latency: checks one cycle after each driven edge.
// Backpressure: none.
module tb_robo_seguidor_param;

    localparam int GC = 4;
    localparam int RC = 3;
    localparam int MT = 2;
    localparam int PW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          head;
    logic          left;
    logic          under;
    logic          barrier;
    logic          avancar;
    logic          girar;
    logic          remover;
    logic [2:0]    estado;
    logic          erro;
    logic [PW-1:0] passos;

    int checks = 0;
    int errors = 0;

    // Reference model: mode number, cycles left in the action, failed attempts, steps, fault.
    int m_est   = 0;
    int m_rem   = 0;
    int m_att   = 0;
    int m_steps = 0;
    bit m_erro  = 1'b0;

    typedef struct {
        bit r;
        bit h;
        bit l;
        bit u;
        bit b;
        int est;
        bit er;
    } vet_t;

    vet_t tab[$];

    always #5 clock = ~clock;

    robo_seguidor_param #(
        .GIRO_CICLOS    (GC),
        .REMOCAO_CICLOS (RC),
        .MAX_TENTATIVAS (MT),
        .PASSOS_W       (PW)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .head    (head),
        .left    (left),
        .under   (under),
        .barrier (barrier),
        .avancar (avancar),
        .girar   (girar),
        .remover (remover),
        .estado  (estado),
        .erro    (erro),
        .passos  (passos)
    );

    function automatic int escolher(bit h, bit l, bit u, bit b);
        if (u) return 5;
        if (b) return 4;
        if (h) return 2;
        if (l) return 3;
        return 1;
    endfunction

    task automatic modelo(bit r, bit h, bit l, bit u, bit b);
        int nxt;
        bool_start: begin end
        if (r) begin
            m_est = 0; m_rem = 0; m_att = 0; m_steps = 0; m_erro = 1'b0;
            return;
        end
        if ((m_est == 1 || m_est == 3) && m_steps < (1 << PW) - 1) m_steps++;
        nxt = m_est;
        if (m_est == 0 || m_est == 1 || m_est == 3) begin
            nxt = escolher(h, l, u, b);
        end else if (m_est == 2) begin
            if (u) nxt = 5;
            else begin
                m_rem--;
                if (m_rem == 0) nxt = escolher(h, l, u, b);
            end
        end else if (m_est == 4) begin
            if (u) nxt = 5;
            else begin
                m_rem--;
                if (m_rem == 0) begin
                    if (!b) nxt = escolher(h, l, u, b);
                    else begin
                        m_att++;
                        if (m_att >= MT) begin nxt = 5; m_erro = 1'b1; end
                        else m_rem = RC;
                    end
                end
            end
        end else begin
            nxt = 5;
        end
        if (nxt != 4) m_att = 0;
        if (nxt == 2 && (m_est != 2 || m_rem == 0)) m_rem = GC;
        if (nxt == 4 && (m_est != 4 || m_rem == 0)) m_rem = RC;
        m_est = nxt;
    endtask

    task automatic ciclo(bit r, bit h, bit l, bit u, bit b);
        int exp_passos;
        reset = r; head = h; left = l; under = u; barrier = b;
        @(posedge clock);
        modelo(r, h, l, u, b);
        #1;
`ifdef ROBO_ODOMETRIA_EN
        exp_passos = m_steps;
`else
        exp_passos = 0;
`endif
        checks++;
        if (int'(estado) != m_est || avancar !== (m_est == 1 || m_est == 3) || girar !== (m_est == 2) ||
            remover !== (m_est == 4) || erro !== m_erro || int'(passos) != exp_passos) begin
            errors++;
            $display("FAIL modelo t=%0t: estado=%0d av=%b gi=%b rm=%b erro=%b passos=%0d, expected estado=%0d erro=%b passos=%0d",
                     $time, estado, avancar, girar, remover, erro, passos, m_est, m_erro, exp_passos);
        end
    endtask

    task automatic add(bit r, bit h, bit l, bit u, bit b, int est, bit er, int n);
        vet_t v;
        v.r = r; v.h = h; v.l = l; v.u = u; v.b = b; v.est = est; v.er = er;
        for (int k = 0; k < n; k++) tab.push_back(v);
    endtask

    task automatic checar_passos(string nome, int esperado);
        checks++;
        if (int'(passos) != esperado) begin
            errors++;
            $display("FAIL %s: passos=%0d expected %0d", nome, passos, esperado);
        end
    endtask

    initial begin
        reset = 1'b1; head = 1'b0; left = 1'b0; under = 1'b0; barrier = 1'b0;

        // Reset, then search, follow wall, rotate with re-rotation, back to wall.
        add(1,0,0,0,0, 0,0, 2);
        add(0,0,0,0,0, 1,0, 1);
        add(0,0,1,0,0, 3,0, 1);
        add(0,1,1,0,0, 2,0, 5);
        add(0,0,1,0,0, 2,0, 3);
        add(0,0,1,0,0, 3,0, 1);
        // Persistent barrier: two full attempts, then sticky fault in standby.
        add(0,0,1,0,1, 4,0, 6);
        add(0,0,1,0,1, 5,1, 1);
        add(0,1,0,0,0, 5,1, 1);
        add(0,0,0,1,1, 5,1, 1);
        add(1,0,0,0,0, 0,0, 1);
        add(0,0,0,0,0, 1,0, 1);
        // Barrier cleared in first attempt, then a new barrier gets both attempts.
        add(0,0,0,0,1, 4,0, 1);
        add(0,0,0,0,0, 4,0, 2);
        add(0,0,0,0,0, 1,0, 1);
        add(0,0,0,0,1, 4,0, 6);
        add(0,0,0,0,1, 5,1, 1);
        add(1,0,0,0,0, 0,0, 1);
        // under in the second rotation cycle aborts immediately.
        add(0,0,0,0,0, 1,0, 1);
        add(0,1,0,0,0, 2,0, 2);
        add(0,1,1,1,1, 5,0, 1);
        add(0,0,1,0,1, 5,0, 2);
        add(1,0,0,0,0, 0,0, 1);
        // under in the last removal cycle beats dispatch.
        add(0,0,0,0,0, 1,0, 1);
        add(0,0,0,0,1, 4,0, 3);
        add(0,0,0,1,0, 5,0, 1);
        add(1,0,0,0,0, 0,0, 1);

        for (int i = 0; i < tab.size(); i++) begin
            ciclo(tab[i].r, tab[i].h, tab[i].l, tab[i].u, tab[i].b);
            checks++;
            if (int'(estado) != tab[i].est || avancar !== (tab[i].est == 1 || tab[i].est == 3) ||
                girar !== (tab[i].est == 2) || remover !== (tab[i].est == 4) || erro !== tab[i].er) begin
                errors++;
                $display("FAIL tabela[%0d]: estado=%0d av=%b gi=%b rm=%b erro=%b, expected estado=%0d erro=%b",
                         i, estado, avancar, girar, remover, erro, tab[i].est, tab[i].er);
            end
        end

        // Odometer: 10 forward cycles, then saturation at the top value.
        ciclo(1,0,0,0,0);
        ciclo(0,0,0,0,0);
        checar_passos("passos_inicio", 0);
        for (int i = 0; i < 10; i++) ciclo(0,0,0,0,0);
`ifdef ROBO_ODOMETRIA_EN
        checar_passos("passos_dez", 10);
`else
        checar_passos("passos_dez", 0);
`endif
        for (int i = 0; i < 250; i++) ciclo(0,0,0,0,0);
`ifdef ROBO_ODOMETRIA_EN
        checar_passos("passos_saturado", 255);
`else
        checar_passos("passos_saturado", 0);
`endif

        // Randomized traffic against the model.
        ciclo(1,0,0,0,0);
        for (int i = 0; i < 3000; i++) begin
            bit r;
            r = ($urandom_range(99) == 0) || (m_est == 5 && $urandom_range(7) == 0);
            ciclo(r, $urandom_range(3) == 0, $urandom_range(1) == 0,
                  $urandom_range(39) == 0, $urandom_range(6) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/robo_seguidor_param.md
# robo_seguidor_param

Parametrised wall-following robot controller, successor to the single-cycle robot FSM. It turns head/left/under/barrier sensor readings into avancar/girar/remover actuator commands. Rotation and barrier removal become timed multi-cycle actions, failed removals are retried a bounded number of times, and the block reports state, fault and an optional step odometer. It sits between the sensor front-end and the motor/actuator drivers, one instance per robot.

## Interface
- GIRO_CICLOS, 4: cycles girar is held per rotation action (≥1)
- REMOCAO_CICLOS, 3: cycles remover is held per removal attempt (≥1)
- MAX_TENTATIVAS, 2: removal attempts before giving up (≥1)
- PASSOS_W, 8: odometer width
- clock  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high; sampled on posedge clock
- head  in  1  obstacle ahead
- left  in  1  wall on left side
- under  in  1  floor hazard; forces Standby
- barrier  in  1  removable barrier ahead
- avancar  out  1  move forward
- girar  out  1  rotate in place
- remover  out  1  drive removal actuator
- estado  out  3  current state encoding
- erro  out  1  sticky: removal gave up
- passos  out  PASSOS_W  forward-step odometer

## Operation
- States: INICIAL=0, PROCURANDO_MURO=1, ROTACIONANDO=2, ACOMPANHANDO_MURO=3, REMOCAO=4, STANDBY=5.
- Encodings 6 and 7 are illegal and go to STANDBY.
- Moore outputs:
  - avancar=1 only in PROCURANDO_MURO and ACOMPANHANDO_MURO.
  - girar=1 only in ROTACIONANDO.
  - remover=1 only in REMOCAO.
  - All outputs are 0 in INICIAL and STANDBY.
- Priority in every evaluation: under > barrier > head > left.
- Dispatch rule (shared by INICIAL, and by the end of a rotation or removal):
  - under → STANDBY
  - barrier → REMOCAO
  - head → ROTACIONANDO
  - left → ACOMPANHANDO_MURO
  - otherwise → PROCURANDO_MURO
- INICIAL: applies dispatch on the first clock after reset is released.
- PROCURANDO_MURO: evaluated every cycle.
  - under → STANDBY; barrier → REMOCAO; head → ROTACIONANDO; left → ACOMPANHANDO_MURO; else stay.
- ACOMPANHANDO_MURO: evaluated every cycle.
  - under → STANDBY; barrier → REMOCAO; head → ROTACIONANDO; !left → PROCURANDO_MURO; else stay.
- ROTACIONANDO:
  - Entry loads the timer with GIRO_CICLOS; girar stays high for exactly GIRO_CICLOS cycles.
  - barrier, head and left are ignored mid-rotation.
  - under aborts to STANDBY immediately.
  - In the last cycle, dispatch is applied. If head is still 1, the state re-enters ROTACIONANDO and the timer reloads.
- REMOCAO:
  - Entry loads the timer with REMOCAO_CICLOS.
  - under aborts to STANDBY.
  - In the last cycle, if barrier=0: the attempt counter clears and dispatch is applied.
  - In the last cycle, if barrier=1: the attempt counter increments. When it reaches MAX_TENTATIVAS the state goes to STANDBY with erro=1; otherwise the attempt restarts and the timer reloads.
  - The attempt counter clears on any exit from REMOCAO.
- STANDBY: absorbing; only reset leaves it.
- passos: increments each cycle avancar=1 and saturates at 2^PASSOS_W−1 (no wrap).
- Timer width is clog2(max(GIRO_CICLOS,REMOCAO_CICLOS)+1).
- Attempt counter width is clog2(MAX_TENTATIVAS+1).

## Timing
- Reset values: estado=INICIAL, avancar=girar=remover=0, erro=0, passos=0, timer=0, attempts=0.
- Reset mid-action aborts the action; outputs are 0 in the cycle after the reset edge.
- All outputs are registered. A sensor value sampled at edge n is reflected in the outputs after edge n.
- Action lengths are exact: GIRO_CICLOS consecutive girar cycles and REMOCAO_CICLOS consecutive remover cycles per attempt, with no idle cycle between back-to-back actions.
- under during the last cycle of an action wins over dispatch.
- barrier dropping mid-removal is not acted on until the last cycle.

## Configuration
- ROBO_ODOMETRIA_EN defined: passos counter implemented as above.
- ROBO_ODOMETRIA_EN undefined: passos is tied to 0 and no counter logic is generated. The port remains.

## Structure
- Package robo_pkg holds:
  - estado_t enum with the encodings above
  - the ESTADO_W=3 constant
  - the dispatch function (sensors → next state)
- Sub-module robo_temporizador: loadable down-counter with a `fim` output in the last cycle. Instantiated once and shared by rotation and removal.

## Test plan
- Reset then {head,left,under,barrier}=0000: INICIAL for 1 cycle, then PROCURANDO_MURO, avancar=1; passos reaches 10 after 10 cycles.
- From ACOMPANHANDO_MURO, head=1 held: girar high exactly 4 cycles, then re-rotate; head dropped with left=1 → ACOMPANHANDO_MURO, avancar=1.
- barrier=1 held: remover high 3+3 cycles, then STANDBY, erro=1, all actuators 0; holds until reset.
- barrier cleared during the first attempt: after 3 remover cycles → dispatch; attempt counter back to 0 (a second barrier gets a full 2 attempts).
- under=1 in cycle 2 of a rotation: next cycle STANDBY, girar=0; sensor changes ignored; reset returns to INICIAL with erro=0.
- passos preset near 255 (PASSOS_W=8): saturates at 255. With ROBO_ODOMETRIA_EN undefined, passos stays 0 throughout.
